// File: rtl/event_seq_pkg.sv
// Shared types for the event sequence monitor: FSM states and error codes.
package event_seq_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE    = 3'd0,
        ERR_WRONG   = 3'd1,
        ERR_MULTI   = 3'd2,
        ERR_EARLY   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_e;

endpackage

// File: rtl/event_onehot_decode.sv
// Combinational decode of the event strobe vector: lowest set index,
// any-bit flag and a flag for two or more bits set in the same cycle.
module event_onehot_decode #(
    parameter int NUM_EVENTS = 4,
    parameter int IDX_W      = $clog2(NUM_EVENTS)
) (
    input  logic [NUM_EVENTS-1:0] ev_i,
    output logic [IDX_W-1:0]      idx,
    output logic                  any,
    output logic                  multi
);

    // Clearing the lowest set bit leaves something only if a second bit is set.
    always_comb begin
        idx   = '0;
        any   = |ev_i;
        multi = |(ev_i & (ev_i - NUM_EVENTS'(1)));
        for (int n = NUM_EVENTS - 1; n >= 0; n--) begin
            if (ev_i[n]) idx = IDX_W'(n);
        end
    end

endmodule

// File: rtl/event_seq_monitor.sv
// Observer for a programmed sequence of one-cycle event strobes. Checks
// order, minimum spacing after each match and a bounded wait, then reports
// done or a classified error. All outputs are registered.
// Optional trace build: define EVENT_SEQ_MONITOR_TRACE_EN to add a cycle
// counter and $display messages; ports and timing are unchanged.
//
// state | meaning
// IDLE  | waiting for start
// ARMED | waiting for event exp[pos], timeout counter running
// GAP   | enforced idle window after a match, any event is an error
// DONE  | whole sequence matched, done held until start/rst
// ERR   | sequence failed, error/err_code held until start/rst
module event_seq_monitor
    import event_seq_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int SEQ_LEN    = 6,
    parameter int IDX_W      = $clog2(NUM_EVENTS),
    parameter int MIN_GAP    = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SEQ_LEN*IDX_W-1:0]     exp_seq,
    input  logic [NUM_EVENTS-1:0]        ev_i,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [ERR_W-1:0]             err_code,
    output logic [$clog2(SEQ_LEN+1)-1:0] pos
);

    localparam int POS_W = $clog2(SEQ_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    state_e                   state_q, state_d;
    err_code_e                err_q, err_d;
    logic [SEQ_LEN*IDX_W-1:0] exp_q, exp_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic [IDX_W-1:0]         ev_idx;
    logic                     ev_any;
    logic                     ev_multi;
    logic [IDX_W-1:0]         exp_cur;

    event_onehot_decode #(
        .NUM_EVENTS (NUM_EVENTS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .ev_i  (ev_i),
        .idx   (ev_idx),
        .any   (ev_any),
        .multi (ev_multi)
    );

    // Select the expected index for the current position from the latched sequence.
    always_comb begin
        exp_cur = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (pos_q == POS_W'(k)) exp_cur = exp_q[k*IDX_W +: IDX_W];
        end
    end

    // Next-state and next-output logic; outputs follow the next state so they register with it.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        exp_d   = exp_q;
        pos_d   = pos_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = ARMED;
                    err_d   = ERR_NONE;
                    exp_d   = exp_seq;
                    pos_d   = '0;
                    tmo_d   = '0;
                    gap_d   = '0;
                end
            end
            ARMED: begin
                if (ev_multi) begin
                    state_d = ERR;
                    err_d   = ERR_MULTI;
                end else if (ev_any) begin
                    if (ev_idx == exp_cur) begin
                        pos_d = pos_q + POS_W'(1);
                        tmo_d = '0;
                        if (pos_q == POS_W'(SEQ_LEN - 1)) begin
                            state_d = DONE;
                        end else if (MIN_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(MIN_GAP);
                        end
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_WRONG;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d = ERR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            GAP: begin
                if (ev_any) begin
                    state_d = ERR;
                    err_d   = ERR_EARLY;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == ARMED) || (state_d == GAP);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
    end

    // FSM state, latched sequence, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            exp_q   <= '0;
            pos_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
            pos_q   <= pos_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_q;
    assign pos      = pos_q;

`ifdef EVENT_SEQ_MONITOR_TRACE_EN
    logic [31:0] cyc_q;

    // Free-running cycle count used only to timestamp trace messages.
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_q + 32'd1;
    end

    // Trace every match and every entry into a terminal state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ARMED && ev_any && !ev_multi && ev_idx == exp_cur)
                $display("ev %0d pos %0d cyc %0d", ev_idx, pos_q, cyc_q);
            if (state_d != state_q && (state_d == DONE || state_d == ERR))
                $display("end state %s err_code %0d cyc %0d", state_d.name(), err_d, cyc_q);
        end
    end
`endif

endmodule

// File: tb/tb_event_seq_monitor.sv
// Directed bench for event_seq_monitor with hand-computed expectations.
module tb_event_seq_monitor;

    localparam int NUM_EVENTS = 4;
    localparam int SEQ_LEN    = 6;
    localparam int IDX_W      = 2;
    localparam int MIN_GAP    = 1;
    localparam int TIMEOUT    = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic [SEQ_LEN*IDX_W-1:0]     exp_seq;
    logic [NUM_EVENTS-1:0]        ev_i;
    logic                         busy;
    logic                         done;
    logic                         error;
    logic [2:0]                   err_code;
    logic [$clog2(SEQ_LEN+1)-1:0] pos;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry 0 is the first expected event: sequence 1,2,3,2,0,3.
    localparam logic [SEQ_LEN*IDX_W-1:0] SEQ_A = {2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1};
    int seq_a [SEQ_LEN] = '{1, 2, 3, 2, 0, 3};

    event_seq_monitor #(
        .NUM_EVENTS (NUM_EVENTS),
        .SEQ_LEN    (SEQ_LEN),
        .MIN_GAP    (MIN_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exp_seq  (exp_seq),
        .ev_i     (ev_i),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int n);
        ev_i    = '0;
        ev_i[n] = 1'b1;
        cyc();
        ev_i = '0;
    endtask

    task automatic do_start(input logic [SEQ_LEN*IDX_W-1:0] seq);
        exp_seq = seq;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int b, input int d, input int e,
                              input int code, input int p);
        check_val({tag, ".busy"}, int'(busy), b);
        check_val({tag, ".done"}, int'(done), d);
        check_val({tag, ".error"}, int'(error), e);
        check_val({tag, ".err_code"}, int'(err_code), code);
        check_val({tag, ".pos"}, int'(pos), p);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        exp_seq = '0;
        ev_i    = '0;
        cyc();
        cyc();
        check_outs("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Full sequence, event in start cycle ignored, exp_seq changed after start,
        // start pulse while busy ignored.
        ev_i = 4'b1000;
        do_start(SEQ_A);
        exp_seq = '1;
        check_outs("armed", 1, 0, 0, 0, 0);
        for (int k = 0; k < SEQ_LEN; k++) begin
            strobe(seq_a[k]);
            if (k < SEQ_LEN - 1) begin
                check_val("seq.pos", int'(pos), k + 1);
                check_val("seq.done_early", int'(done), 0);
                if (k == 1) start = 1'b1;
                cyc();
                start = 1'b0;
            end
        end
        check_outs("seq_done", 0, 1, 0, 0, 6);
        strobe(1);
        cyc();
        check_outs("done_sticky", 0, 1, 0, 0, 6);

        // Wrong event at entry 2.
        do_start(SEQ_A);
        check_val("restart.done_clear", int'(done), 0);
        strobe(1); cyc();
        strobe(2); cyc();
        strobe(0);
        check_outs("wrong", 0, 0, 1, 1, 2);
        cyc();
        check_outs("wrong_sticky", 0, 0, 1, 1, 2);

        // Two events in one cycle.
        do_start(SEQ_A);
        check_outs("rearm", 1, 0, 0, 0, 0);
        ev_i = 4'b0110;
        cyc();
        ev_i = '0;
        check_outs("multi", 0, 0, 1, 2, 0);

        // Event inside the gap.
        do_start(SEQ_A);
        strobe(1);
        strobe(2);
        check_outs("early", 0, 0, 1, 3, 1);

        // Timeout: error visible 9 cycles after the start cycle.
        do_start(SEQ_A);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc();
        check_val("tmo.before", int'(error), 0);
        check_val("tmo.busy_before", int'(busy), 1);
        cyc();
        check_outs("tmo", 0, 0, 1, 4, 0);

        // Reset while ARMED at pos 3, then events ignored in IDLE, then full run.
        do_start(SEQ_A);
        strobe(1); cyc();
        strobe(2); cyc();
        strobe(3); cyc();
        check_outs("pre_rst", 1, 0, 0, 0, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_outs("mid_rst", 0, 0, 0, 0, 0);
        strobe(1);
        cyc();
        check_outs("idle_ignore", 0, 0, 0, 0, 0);
        do_start(SEQ_A);
        for (int k = 0; k < SEQ_LEN; k++) begin
            strobe(seq_a[k]);
            if (k < SEQ_LEN - 1) cyc();
        end
        check_outs("post_rst_done", 0, 1, 0, 0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/event_seq_monitor.md
Name: event_seq_monitor

Overview:
- Responder/observer side of the named-event handshake used in our scheduler tests. A sequence of processes fire one-cycle event strobes; this block consumes those strobes.
- It checks that the events arrive in a programmed order, with an enforced minimum spacing and a bounded wait. It then reports done or a classified error.
- It sits beside the event producers in a testbench or DUT harness and is the hardware counterpart of the "wait on event, then act" chains.

Parameters:
- NUM_EVENTS, 4, number of event strobe inputs.
- SEQ_LEN, 6, number of events in the expected sequence (>=1).
- IDX_W, $clog2(NUM_EVENTS), width of one event index (derived; do not override).
- MIN_GAP, 1, required idle cycles after each matched event before the next one is allowed (0 = back-to-back allowed).
- TIMEOUT, 255, maximum idle cycles in ARMED before a timeout error (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; arms the monitor and captures exp_seq.
- exp_seq  in  SEQ_LEN*IDX_W  expected event indices; entry k is at bits [k*IDX_W +: IDX_W].
- ev_i  in  NUM_EVENTS  event strobes; bit n high for one cycle = event n fired.
- busy  out  1  high in ARMED or GAP.
- done  out  1  sticky; whole sequence matched.
- error  out  1  sticky; sequence failed.
- err_code  out  3  0 none, 1 wrong event, 2 multiple events in one cycle, 3 event during gap, 4 timeout.
- pos  out  $clog2(SEQ_LEN+1)  count of events matched so far.

Behaviour:
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- rst overrides all other inputs.
- States: IDLE, ARMED, GAP, DONE, ERR.
- IDLE/DONE/ERR, start=1:
  - next cycle: ARMED; busy=1; done=0; error=0; err_code=0; pos=0; timeout counter=0.
  - exp_seq is latched internally, so later changes to exp_seq are ignored.
  - ev_i in the start cycle is ignored.
- start while busy is ignored.
- ARMED, ev_i==0: timeout counter increments. When it reaches TIMEOUT, go to ERR with code 4.
- ARMED, exactly one bit set, index == exp[pos]:
  - pos increments; timeout counter clears.
  - If this was entry SEQ_LEN-1: go to DONE, done=1 in the following cycle.
  - Else if MIN_GAP>0: go to GAP, gap counter=MIN_GAP.
  - Else: stay in ARMED.
- ARMED, exactly one bit set, index != exp[pos]: ERR, code 1.
- ARMED, two or more bits set: ERR, code 2. This takes priority over code 1.
- GAP:
  - Any ev_i bit set goes to ERR with code 3.
  - Otherwise the gap counter decrements. In the cycle it reaches 0, go to ARMED.
  - The timeout counter does not run in GAP.
- ERR: pos holds the index of the failing entry. done and error stay asserted until start or rst.
- Events arriving in IDLE, DONE or ERR are ignored.
- Latency: done/error assert 1 cycle after the deciding ev_i cycle.

Optional Feature:
- Macro EVENT_SEQ_MONITOR_TRACE_EN.
- Defined:
  - an internal free-running 32-bit cycle counter (cleared by rst);
  - a $display on every match ("ev <idx> pos <pos> cyc <n>") and on entry to DONE/ERR with err_code.
- Undefined: no counter and no display statements. Ports and cycle behaviour are identical either way.

Decomposition:
- Package event_seq_pkg:
  - state_e enum (IDLE, ARMED, GAP, DONE, ERR);
  - err_code_e enum (ERR_NONE=0, ERR_WRONG=1, ERR_MULTI=2, ERR_EARLY=3, ERR_TIMEOUT=4);
  - width of err_code.
- One sub-module, event_onehot_decode (combinational): ev_i -> idx, any, multi.

Test Plan:
- NUM_EVENTS=4, exp_seq={1,2,3,2,0,3}, MIN_GAP=1. Pulse start, then single strobes 1,2,3,2,0,3 each 2 cycles apart -> done=1 one cycle after the last strobe; pos=6; err_code=0; busy=0.
- Same sequence with the third strobe as event 0 -> error=1, err_code=1, pos=2, done=0.
- ev_i=4'b0110 as the first event -> err_code=2, pos=0.
- Strobe 1, then strobe 2 on the very next cycle (inside the gap) -> err_code=3, pos=1.
- TIMEOUT=8; start, then no events -> error=1, err_code=4 exactly 9 cycles after start (8 idle cycles counted, plus 1 cycle for the registered output).
- Assert rst while ARMED with pos=3 -> next cycle all outputs 0 and state IDLE. Strobes before the next start are ignored; a new start followed by the full sequence then gives done=1.
